// File: rtl/stg_pipe_latch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stg_pipe_latch_pkg
//  Purpose  : Shared sizes, NOP encoding and load-source selection helper for
//             the pipeline-stage register stg_pipe_latch.
//  Contents : SIZE_ADDR / SIZE_DATA / HBIT_ADDR / HBIT_DATA  bus sizes
//             NOP_INSTR   shared bubble encoding (default for P_NOP)
//             ld_src_e    what the output register does this cycle
//             sel_load_src()  priority selection of the load source
//  Revision : 1.0  initial release
// ============================================================================
package stg_pipe_latch_pkg;

  localparam int SIZE_ADDR = 32;
  localparam int SIZE_DATA = 32;
  localparam int HBIT_ADDR = SIZE_ADDR - 1;
  localparam int HBIT_DATA = SIZE_DATA - 1;

  localparam logic [SIZE_DATA-1:0] NOP_INSTR = '0;

  typedef enum logic [2:0] {
    LD_HOLD   = 3'd0,  // output stalled, keep contents
    LD_FLUSH  = 3'd1,  // squash to a bubble
    LD_SKID   = 3'd2,  // drain the skid entry
    LD_INPUT  = 3'd3,  // take the upstream beat
    LD_BUBBLE = 3'd4   // nothing to load, insert a bubble
  } ld_src_e;

  // Flush beats everything; otherwise the register only changes when it is
  // free to load, and then the older skid entry goes ahead of new input.
  function automatic ld_src_e sel_load_src(input logic flush,
                                           input logic load,
                                           input logic skid_full,
                                           input logic up_xfer);
    ld_src_e src;
    src = LD_HOLD;
    if (flush)          src = LD_FLUSH;
    else if (load) begin
      if (skid_full)    src = LD_SKID;
      else if (up_xfer) src = LD_INPUT;
      else              src = LD_BUBBLE;
    end
    return src;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stg_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : stg_skid_buf
//  Purpose  : One-entry {pc, instr} holding register with full/empty flags,
//             catching a beat accepted while the stage output is stalled.
//  Ports    : iw_clk, iw_rst (async, active-high)
//             iw_wr     capture iw_pc/iw_instr, entry becomes full
//             iw_rd     entry consumed, becomes empty
//             iw_clr    discard the entry (flush), highest priority
//             ow_pc, ow_instr   held entry
//             ow_full, ow_empty registered occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module stg_skid_buf #(
  parameter int P_W_ADDR = 32,
  parameter int P_W_DATA = 32
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_wr,
  input  logic                iw_rd,
  input  logic                iw_clr,
  input  logic [P_W_ADDR-1:0] iw_pc,
  input  logic [P_W_DATA-1:0] iw_instr,
  output logic [P_W_ADDR-1:0] ow_pc,
  output logic [P_W_DATA-1:0] ow_instr,
  output logic                ow_full,
  output logic                ow_empty
);

  // ow_empty is kept as its own flop so the upstream ready driven from it is
  // a pure register output.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      ow_full  <= 1'b0;
      ow_empty <= 1'b1;
      ow_pc    <= '0;
      ow_instr <= '0;
    end else if (iw_clr) begin
      ow_full  <= 1'b0;
      ow_empty <= 1'b1;
    end else if (iw_wr) begin
      ow_full  <= 1'b1;
      ow_empty <= 1'b0;
      ow_pc    <= iw_pc;
      ow_instr <= iw_instr;
    end else if (iw_rd) begin
      ow_full  <= 1'b0;
      ow_empty <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stg_pipe_latch.sv
`default_nettype none
// ============================================================================
//  Module   : stg_pipe_latch
//  Purpose  : Pipeline-stage register carrying {pc, instr} across a stage
//             boundary with valid/ready handshakes, synchronous flush to a
//             NOP bubble and a saturating stall counter.
//  Config   : `define STG_PIPE_SKID_EN adds a 1-entry skid buffer so that
//             ow_ready is a flop; without it ow_ready = ~ow_valid | iw_ready.
//  Ports    : iw_clk, iw_rst (async, active-high)
//             iw_valid/ow_ready/iw_pc/iw_instr      upstream side
//             ow_valid/iw_ready/ow_pc/ow_instr      downstream side
//             iw_flush      squash held and incoming beats
//             iw_cnt_clr    clear the stall counter
//             ow_stall_cnt  cycles with ow_valid & ~iw_ready (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module stg_pipe_latch
  import stg_pipe_latch_pkg::*;
#(
  parameter int                  P_W_ADDR = SIZE_ADDR,
  parameter int                  P_W_DATA = SIZE_DATA,
  parameter logic [P_W_DATA-1:0] P_NOP    = P_W_DATA'(NOP_INSTR),
  parameter int                  P_W_CNT  = 16
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_valid,
  output logic                ow_ready,
  input  logic [P_W_ADDR-1:0] iw_pc,
  input  logic [P_W_DATA-1:0] iw_instr,
  output logic                ow_valid,
  input  logic                iw_ready,
  output logic [P_W_ADDR-1:0] ow_pc,
  output logic [P_W_DATA-1:0] ow_instr,
  input  logic                iw_flush,
  input  logic                iw_cnt_clr,
  output logic [P_W_CNT-1:0]  ow_stall_cnt
);

  localparam logic [P_W_CNT-1:0] CNT_MAX = '1;

  logic                load;
  logic                up_xfer;
  logic                skid_full;
  logic [P_W_ADDR-1:0] skid_pc;
  logic [P_W_DATA-1:0] skid_instr;
  ld_src_e             ld_src;

  // Output register is free whenever it is empty or its beat leaves now.
  assign load    = ~ow_valid | iw_ready;
  assign up_xfer = iw_valid & ow_ready;

`ifdef STG_PIPE_SKID_EN
  logic skid_empty;
  logic skid_wr;
  logic skid_rd;

  // A beat accepted while the output cannot load parks in the skid.
  assign skid_wr  = up_xfer & ~load & ~iw_flush;
  assign skid_rd  = (ld_src == LD_SKID);
  assign ow_ready = skid_empty;

  stg_skid_buf #(
    .P_W_ADDR (P_W_ADDR),
    .P_W_DATA (P_W_DATA)
  ) u_skid (
    .iw_clk   (iw_clk),
    .iw_rst   (iw_rst),
    .iw_wr    (skid_wr),
    .iw_rd    (skid_rd),
    .iw_clr   (iw_flush),
    .iw_pc    (iw_pc),
    .iw_instr (iw_instr),
    .ow_pc    (skid_pc),
    .ow_instr (skid_instr),
    .ow_full  (skid_full),
    .ow_empty (skid_empty)
  );
`else
  assign ow_ready   = load;
  assign skid_full  = 1'b0;
  assign skid_pc    = '0;
  assign skid_instr = '0;
`endif

  always_comb begin
    ld_src = sel_load_src(iw_flush, load, skid_full, up_xfer);
  end

  // ow_pc is never cleared by a bubble or flush; only ow_instr returns to NOP.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      ow_valid <= 1'b0;
      ow_pc    <= '0;
      ow_instr <= P_NOP;
    end else begin
      case (ld_src)
        LD_FLUSH, LD_BUBBLE: begin
          ow_valid <= 1'b0;
          ow_instr <= P_NOP;
        end
        LD_SKID: begin
          ow_valid <= 1'b1;
          ow_pc    <= skid_pc;
          ow_instr <= skid_instr;
        end
        LD_INPUT: begin
          ow_valid <= 1'b1;
          ow_pc    <= iw_pc;
          ow_instr <= iw_instr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      ow_stall_cnt <= '0;
    end else if (iw_cnt_clr) begin
      ow_stall_cnt <= '0;
    end else if (ow_valid && !iw_ready && !iw_flush && ow_stall_cnt != CNT_MAX) begin
      ow_stall_cnt <= ow_stall_cnt + P_W_CNT'(1);
    end
  end

endmodule
`default_nettype wire
